coincidence_scan_controller: RTL

- Sysclk-domain sequencer that drives the coincidence recorder CSR in place of software.
- Arms one histogram acquisition and waits for it to complete.
- Reads back every sample bin of one selected channel and locates the first rising threshold crossing, with wrap.
- Programs the coincidence point (crossing + offset) into the recorder, and can optionally request transmitter heartbeat realignment.

---
 rtl/coincidence_scan_controller.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/coincidence_scan_controller.sv
// Sysclk-domain sequencer for the coincidence recorder CSR: arms one acquisition, scans one
// channel's histogram for the first rising threshold crossing and programs the coincidence point.
module coincidence_scan_controller #(
   parameter int SAMPLE_CLKS_PER_COINCIDENCE = 40,
   parameter int CYCLES_PER_ACQUISITION      = 1023,
   parameter int CHANNEL_COUNT               = 4,
   parameter int BUSY_TIMEOUT                = 65535,
   parameter int ECHO_TIMEOUT                = 255,
   parameter int AW                          = $clog2(SAMPLE_CLKS_PER_COINCIDENCE),
   parameter int CW                          = $clog2(CHANNEL_COUNT)
) (
   input  logic          sysClk,
   input  logic          sysRst_n,
   input  logic          scanStart,
   input  logic [CW-1:0] scanChannel,
   input  logic [AW-1:0] scanOffset,
   input  logic          scanRealign,
   output logic          csrStrobe,
   output logic [31:0]   csrData,
   input  logic [31:0]   csrStatus,
   output logic          scanBusy,
   output logic          scanDone,
   output logic [1:0]    scanError,
   output logic [AW-1:0] edgeAddress
);

   localparam int N    = SAMPLE_CLKS_PER_COINCIDENCE;
   localparam int SW   = $clog2(CYCLES_PER_ACQUISITION + 1);
   localparam int EW   = 24 - SW;
   localparam int AW1  = AW + 1;
   localparam int TMAX = (BUSY_TIMEOUT > ECHO_TIMEOUT) ? BUSY_TIMEOUT : ECHO_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [SW-1:0]  THR     = SW'((CYCLES_PER_ACQUISITION + 1) / 2);
   localparam logic [AW-1:0]  LAST    = AW'(N - 1);
   localparam logic [AW1-1:0] N_W     = AW1'(N);
   localparam logic [1:0]     ERR_OK   = 2'd0;
   localparam logic [1:0]     ERR_BUSY = 2'd1;
   localparam logic [1:0]     ERR_ECHO = 2'd2;
   localparam logic [1:0]     ERR_NONE = 2'd3;

   typedef enum logic [3:0] {
      StIdle, StArm, StWaitRise, StWaitFall, StReq, StPoll, StEval, StWrap,
      StProgram, StGap, StRealign, StFinish
   } state_t;

   state_t         r_state, w_state_nxt;
   logic [CW-1:0]  r_chan;
   logic [AW-1:0]  r_off;
   logic           r_realign;
   logic [AW-1:0]  r_addr;
   logic [TW-1:0]  r_tmo;
   logic           r_match;
   logic [SW-1:0]  r_sum, r_bin0, r_prev;
   logic           r_found;
   logic [AW-1:0]  r_cross;
   logic [AW-1:0]  r_edge;
   logic [1:0]     r_err;

   logic           w_busy, w_echo_ok, w_rise, w_wrap_hit, w_tmo_busy, w_tmo_echo;
   logic           w_err_set;
   logic [1:0]     w_err_val;
   logic [AW-1:0]  w_cross, w_edge;
   logic [AW1-1:0] w_edge_sum;

   assign w_busy     = csrStatus[31];
   assign w_echo_ok  = (csrStatus[30:24] == 7'(r_chan)) && (csrStatus[23:SW] == EW'(r_addr));
   // In EVAL r_prev holds sum[a-1]; in WRAP it holds sum[N-1], the predecessor of bin 0.
   assign w_rise     = (r_prev < THR) && (r_sum >= THR);
   assign w_wrap_hit = (r_prev < THR) && (r_bin0 >= THR);
   assign w_tmo_busy = (r_tmo == TW'(BUSY_TIMEOUT));
   assign w_tmo_echo = (r_tmo == TW'(ECHO_TIMEOUT));
   assign w_cross    = r_found ? r_cross : '0;
   assign w_edge_sum = AW1'(w_cross) + AW1'(r_off);
   assign w_edge     = (w_edge_sum >= N_W) ? AW'(w_edge_sum - N_W) : AW'(w_edge_sum);

   assign scanError   = r_err;
   assign edgeAddress = r_edge;

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_err_set   = 1'b0;
      w_err_val   = ERR_OK;
      csrStrobe   = 1'b0;
      csrData     = '0;
      scanBusy    = 1'b1;
      scanDone    = 1'b0;
      case (r_state)
         StIdle: begin
            scanBusy = 1'b0;
            if (scanStart) w_state_nxt = StArm;
         end
         StArm: begin
            csrStrobe   = 1'b1;
            csrData     = 32'h8000_0000;
            w_state_nxt = StWaitRise;
         end
         StWaitRise: begin
            if (w_busy) begin
               w_state_nxt = StWaitFall;
            end else if (w_tmo_busy) begin
               w_state_nxt = StFinish;
               w_err_set   = 1'b1;
               w_err_val   = ERR_BUSY;
            end
         end
         StWaitFall: begin
            if (!w_busy) begin
               w_state_nxt = StReq;
            end else if (w_tmo_busy) begin
               w_state_nxt = StFinish;
               w_err_set   = 1'b1;
               w_err_val   = ERR_BUSY;
            end
         end
         StReq: begin
            csrStrobe   = 1'b1;
            csrData     = (32'(r_chan) << 24) | 32'(r_addr);
            w_state_nxt = StPoll;
         end
         StPoll: begin
            if (w_echo_ok && r_match) begin
               w_state_nxt = StEval;
            end else if (w_tmo_echo) begin
               w_state_nxt = StFinish;
               w_err_set   = 1'b1;
               w_err_val   = ERR_ECHO;
            end
         end
         StEval: w_state_nxt = (r_addr == LAST) ? StWrap : StReq;
         StWrap: begin
            if (r_found || w_wrap_hit) begin
               w_state_nxt = StProgram;
            end else begin
               w_state_nxt = StFinish;
               w_err_set   = 1'b1;
               w_err_val   = ERR_NONE;
            end
         end
         StProgram: begin
            csrStrobe   = 1'b1;
            csrData     = 32'h4000_0000 | 32'(r_edge);
            w_state_nxt = r_realign ? StGap : StFinish;
         end
         // Keeps an idle cycle between the program and realign strobes.
         StGap: w_state_nxt = StRealign;
         StRealign: begin
            csrStrobe   = 1'b1;
            csrData     = 32'h2000_0000;
            w_state_nxt = StFinish;
         end
         StFinish: begin
            scanBusy    = 1'b0;
            scanDone    = 1'b1;
            w_state_nxt = StIdle;
         end
         default: begin
            scanBusy    = 1'b0;
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         r_chan    <= '0;
         r_off     <= '0;
         r_realign <= 1'b0;
         r_addr    <= '0;
         r_tmo     <= '0;
         r_match   <= 1'b0;
         r_sum     <= '0;
         r_bin0    <= '0;
         r_prev    <= '0;
         r_found   <= 1'b0;
         r_cross   <= '0;
         r_edge    <= '0;
         r_err     <= ERR_OK;
      end else begin
         r_tmo   <= ((w_state_nxt != r_state) || (r_state == StIdle)) ? '0 : r_tmo + TW'(1);
         r_match <= (r_state == StPoll) && w_echo_ok;
         if (w_err_set) r_err <= w_err_val;
         case (r_state)
            StIdle: begin
               if (scanStart) begin
                  r_chan    <= scanChannel;
                  r_off     <= scanOffset;
                  r_realign <= scanRealign;
                  r_addr    <= '0;
                  r_found   <= 1'b0;
                  r_err     <= ERR_OK;
               end
            end
            StPoll: begin
               if (w_echo_ok && r_match) r_sum <= csrStatus[SW-1:0];
            end
            StEval: begin
               if (r_addr == '0) begin
                  r_bin0 <= r_sum;
               end else if (!r_found && w_rise) begin
                  r_found <= 1'b1;
                  r_cross <= r_addr;
               end
               r_prev <= r_sum;
               if (r_addr != LAST) r_addr <= r_addr + AW'(1);
            end
            StWrap: begin
               if (r_found || w_wrap_hit) r_edge <= w_edge;
            end
            default: ;
         endcase
      end
   end

endmodule
